// File: rtl/data_cache.sv
// Direct-mapped write-back, write-allocate data cache between the CPU load/store path and data memory.
// Latency: hits complete in the request cycle; misses stall 1 + (write-back cycles) + fetch cycles.
// Backpressure: busywait_o stalls the CPU combinationally; mem_busywait_i holds each line transfer.
module data_cache #(
  parameter int INDEX_W  = 3,
  parameter int OFFSET_W = 2,
  parameter int TAG_W    = 8 - INDEX_W - OFFSET_W,
  parameter int MEM_AW   = 8 - OFFSET_W,
  parameter int MEM_DW   = 8 << OFFSET_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              read_i,
  input  logic              write_i,
  input  logic [7:0]        address_i,
  input  logic [7:0]        writedata_i,
  output logic [7:0]        readdata_o,
  output logic              busywait_o,
  output logic              mem_read_o,
  output logic              mem_write_o,
  output logic [MEM_AW-1:0] mem_address_o,
  output logic [MEM_DW-1:0] mem_writedata_o,
  input  logic [MEM_DW-1:0] mem_readdata_i,
  input  logic              mem_busywait_i
);

  localparam int NUM_SETS = 2 ** INDEX_W;

  typedef enum logic [1:0] {IDLE, WRITE_BACK, FETCH} state_e;

  state_e               state_q, state_d;
  logic [TAG_W-1:0]     miss_tag_q, miss_tag_d;
  logic [INDEX_W-1:0]   miss_idx_q, miss_idx_d;

  logic [MEM_DW-1:0]    data_q  [NUM_SETS];
  logic [TAG_W-1:0]     tag_q   [NUM_SETS];
  logic [NUM_SETS-1:0]  valid_q;
  logic [NUM_SETS-1:0]  dirty_q;

  logic [TAG_W-1:0]     addr_tag;
  logic [INDEX_W-1:0]   addr_idx;
  logic [OFFSET_W-1:0]  addr_off;
  logic                 req;
  logic                 hit;

  assign addr_tag = address_i[7 -: TAG_W];
  assign addr_idx = address_i[OFFSET_W +: INDEX_W];
  assign addr_off = address_i[OFFSET_W-1:0];
  assign req      = read_i | write_i;
  assign hit      = valid_q[addr_idx] && (tag_q[addr_idx] == addr_tag);

  // Load data is a straight byte select of the indexed line, no added latency.
  assign readdata_o = data_q[addr_idx][{addr_off, 3'b000} +: 8];

  // State and captured miss address; reset abandons any in-flight transfer.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      miss_tag_q <= '0;
      miss_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      miss_tag_q <= miss_tag_d;
      miss_idx_q <= miss_idx_d;
    end
  end

  // Next-state and memory-side outputs; the CPU stall is masked while reset is held.
  always_comb begin
    state_d         = state_q;
    miss_tag_d      = miss_tag_q;
    miss_idx_d      = miss_idx_q;
    mem_read_o      = 1'b0;
    mem_write_o     = 1'b0;
    mem_address_o   = '0;
    mem_writedata_o = '0;
    busywait_o      = !rst_i && req && !(state_q == IDLE && hit);
    case (state_q)
      IDLE: begin
        if (req && !hit) begin
          miss_tag_d = addr_tag;
          miss_idx_d = addr_idx;
          state_d    = (valid_q[addr_idx] && dirty_q[addr_idx]) ? WRITE_BACK : FETCH;
        end
      end
      WRITE_BACK: begin
        mem_write_o     = 1'b1;
        mem_address_o   = {tag_q[miss_idx_q], miss_idx_q};
        mem_writedata_o = data_q[miss_idx_q];
        // A dropped request still finishes the victim write, then gives up the fetch.
        if (!mem_busywait_i) state_d = req ? FETCH : IDLE;
      end
      FETCH: begin
        mem_read_o    = 1'b1;
        mem_address_o = {miss_tag_q, miss_idx_q};
        if (!mem_busywait_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Line storage: store hits merge a byte, write-back completion cleans, fetch completion refills.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_SETS; i++) begin
        data_q[i] <= '0;
        tag_q[i]  <= '0;
      end
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      if (state_q == IDLE && write_i && hit) begin
        data_q[addr_idx][{addr_off, 3'b000} +: 8] <= writedata_i;
        dirty_q[addr_idx]                         <= 1'b1;
      end
      if (state_q == WRITE_BACK && !mem_busywait_i) begin
        dirty_q[miss_idx_q] <= 1'b0;
      end
      if (state_q == FETCH && !mem_busywait_i) begin
        data_q[miss_idx_q]  <= mem_readdata_i;
        tag_q[miss_idx_q]   <= miss_tag_q;
        valid_q[miss_idx_q] <= 1'b1;
        dirty_q[miss_idx_q] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_data_cache.sv
// Directed bench for data_cache: hits, write hits, clean and dirty misses, reset mid-miss.
// Memory handshake is driven step by step so every transfer's timing is explicit.
// Outputs are sampled 1-2 time units after the rising edge.
module tb_data_cache;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        read_i;
  logic        write_i;
  logic [7:0]  address_i;
  logic [7:0]  writedata_i;
  logic [7:0]  readdata_o;
  logic        busywait_o;
  logic        mem_read_o;
  logic        mem_write_o;
  logic [5:0]  mem_address_o;
  logic [31:0] mem_writedata_o;
  logic [31:0] mem_readdata_i;
  logic        mem_busywait_i;

  int n_total = 0;
  int n_fail  = 0;

  data_cache dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .read_i          (read_i),
    .write_i         (write_i),
    .address_i       (address_i),
    .writedata_i     (writedata_i),
    .readdata_o      (readdata_o),
    .busywait_o      (busywait_o),
    .mem_read_o      (mem_read_o),
    .mem_write_o     (mem_write_o),
    .mem_address_o   (mem_address_o),
    .mem_writedata_o (mem_writedata_o),
    .mem_readdata_i  (mem_readdata_i),
    .mem_busywait_i  (mem_busywait_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_i = 1'b0; read_i = 1'b0; write_i = 1'b0; address_i = 8'h00; writedata_i = 8'h00;
    mem_readdata_i = 32'h0; mem_busywait_i = 1'b0;
    #1 rst_i = 1'b1;
    tick(); tick();

    // Reset state
    check("rst_readdata",  readdata_o,      32'h00);
    check("rst_busywait",  busywait_o,      32'h0);
    check("rst_mem_read",  mem_read_o,      32'h0);
    check("rst_mem_write", mem_write_o,     32'h0);
    check("rst_mem_addr",  mem_address_o,   32'h00);
    check("rst_mem_wdata", mem_writedata_o, 32'h0);
    rst_i = 1'b0;

    // 1: cold read miss at 0x00, five busy fetch cycles
    read_i = 1'b1; address_i = 8'h00; mem_busywait_i = 1'b1; #1;
    check("t1_bw_rise",    busywait_o, 32'h1);
    check("t1_idle_nomem", mem_read_o, 32'h0);
    tick();
    check("t1_fetch_rd",   mem_read_o,    32'h1);
    check("t1_fetch_wr",   mem_write_o,   32'h0);
    check("t1_fetch_addr", mem_address_o, 32'h00);
    check("t1_fetch_bw",   busywait_o,    32'h1);
    for (int i = 0; i < 5; i++) tick();
    check("t1_still_fetch", mem_read_o, 32'h1);
    mem_busywait_i = 1'b0; mem_readdata_i = 32'hDDCCBBAA;
    tick();
    check("t1_done_bw",  busywait_o, 32'h0);
    check("t1_done_rd",  readdata_o, 32'hAA);
    check("t1_done_mem", mem_read_o, 32'h0);
    address_i = 8'h03; #1;
    check("t1_hit3_rd",  readdata_o, 32'hDD);
    check("t1_hit3_bw",  busywait_o, 32'h0);
    check("t1_hit3_mem", mem_read_o, 32'h0);

    // 2: write hit at 0x01, no stall, no memory traffic
    read_i = 1'b0; write_i = 1'b1; address_i = 8'h01; writedata_i = 8'h55; mem_busywait_i = 1'b1; #1;
    check("t2_bw",     busywait_o,  32'h0);
    check("t2_mem_rd", mem_read_o,  32'h0);
    check("t2_mem_wr", mem_write_o, 32'h0);
    tick();
    write_i = 1'b0; read_i = 1'b1; address_i = 8'h01; #1;
    check("t2_readback", readdata_o, 32'h55);
    check("t2_rb_bw",    busywait_o, 32'h0);

    // 3: conflict miss at 0x21 evicts the dirty line at index 0
    address_i = 8'h21; #1;
    check("t3_bw_rise", busywait_o, 32'h1);
    tick();
    check("t3_wb_wr",    mem_write_o,     32'h1);
    check("t3_wb_rd",    mem_read_o,      32'h0);
    check("t3_wb_addr",  mem_address_o,   32'h00);
    check("t3_wb_wdata", mem_writedata_o, 32'hDDCC55AA);
    tick();
    check("t3_wb_hold", mem_write_o, 32'h1);
    mem_busywait_i = 1'b0;
    tick();
    check("t3_fetch_rd",   mem_read_o,    32'h1);
    check("t3_fetch_wr",   mem_write_o,   32'h0);
    check("t3_fetch_addr", mem_address_o, 32'h08);
    mem_readdata_i = 32'h44332211;
    tick();
    check("t3_done_bw", busywait_o, 32'h0);
    check("t3_done_rd", readdata_o, 32'h22);

    // 4: clean write miss at 0x46: fetch only, then merge the store
    read_i = 1'b0; write_i = 1'b1; address_i = 8'h46; writedata_i = 8'h77; mem_busywait_i = 1'b1; #1;
    check("t4_bw_rise", busywait_o, 32'h1);
    tick();
    check("t4_fetch_rd",   mem_read_o,    32'h1);
    check("t4_fetch_wr",   mem_write_o,   32'h0);
    check("t4_fetch_addr", mem_address_o, 32'h11);
    mem_busywait_i = 1'b0; mem_readdata_i = 32'h87654321;
    tick();
    check("t4_merge_bw", busywait_o,  32'h0);
    check("t4_merge_wr", mem_write_o, 32'h0);
    tick();
    write_i = 1'b0; read_i = 1'b1; #1;
    check("t4_rd46", readdata_o, 32'h77);
    check("t4_bw46", busywait_o, 32'h0);
    address_i = 8'h45; #1;
    check("t4_rd45", readdata_o, 32'h43);

    // 5: reset asserted while a fetch is stalled
    address_i = 8'h00; mem_busywait_i = 1'b1; #1;
    check("t5_bw_rise", busywait_o, 32'h1);
    tick();
    check("t5_fetch_rd", mem_read_o, 32'h1);
    rst_i = 1'b1; #1;
    check("t5_rst_rd", mem_read_o, 32'h0);
    check("t5_rst_bw", busywait_o, 32'h0);
    check("t5_rst_rdata", readdata_o, 32'h00);
    tick();
    rst_i = 1'b0; #1;
    check("t5_remiss_bw", busywait_o, 32'h1);
    tick();
    check("t5_refetch_rd",   mem_read_o,    32'h1);
    check("t5_refetch_addr", mem_address_o, 32'h00);
    mem_busywait_i = 1'b0; mem_readdata_i = 32'h0A0B0C0D;
    tick();
    check("t5_done_rd", readdata_o, 32'h0D);
    check("t5_done_bw", busywait_o, 32'h0);

    // 6: READ and WRITE together on a hit: the store wins
    write_i = 1'b1; address_i = 8'h02; writedata_i = 8'h99; #1;
    check("t6_bw",     busywait_o, 32'h0);
    check("t6_old_rd", readdata_o, 32'h0B);
    tick();
    check("t6_new_rd", readdata_o, 32'h99);
    write_i = 1'b0; #1;
    check("t6_new_rd2", readdata_o, 32'h99);
    // the merged byte makes the line dirty: a conflict miss writes it back
    address_i = 8'h22; mem_busywait_i = 1'b1; #1;
    check("t6_evict_bw", busywait_o, 32'h1);
    tick();
    check("t6_evict_wr",    mem_write_o,     32'h1);
    check("t6_evict_wdata", mem_writedata_o, 32'h0A990C0D);
    read_i = 1'b0;

    $display("%0d/%0d checks passed", n_total - n_fail, n_total);
    $finish;
  end

endmodule
